// File: rtl/id_exe_stall_reg_if.sv
// ID/EXE stall register bus: ID-stage inputs, EXE-stage outputs and hazard/freeze controls.
// STALL_STATS_EN adds the stall_cycles / flush_count statistic outputs.
interface id_exe_stall_reg_if #(
    parameter int unsigned PAY_W = 140
);
    logic             freeze_mem;
    logic             hazard;
    logic             flush;
    logic [8:0]       id_ctrl;
    logic [PAY_W-1:0] id_payload;
    logic [3:0]       id_dest;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;

    logic [8:0]       exe_ctrl;
    logic [PAY_W-1:0] exe_payload;
    logic [3:0]       exe_dest;
    logic [3:0]       exe_src1;
    logic [3:0]       exe_src2;
    logic             exe_valid;
    logic             WB_EXE;
    logic             MEM_R_EN_EXE;
    logic             pc_freeze;
    logic             ifid_freeze;
    logic             ifid_flush;
    logic             stall_err;
`ifdef STALL_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;
`endif

    modport master (
`ifdef STALL_STATS_EN
        input  stall_cycles, flush_count,
`endif
        output freeze_mem, hazard, flush, id_ctrl, id_payload, id_dest, id_src1, id_src2,
        input  exe_ctrl, exe_payload, exe_dest, exe_src1, exe_src2, exe_valid,
               WB_EXE, MEM_R_EN_EXE, pc_freeze, ifid_freeze, ifid_flush, stall_err
    );

    modport slave (
`ifdef STALL_STATS_EN
        output stall_cycles, flush_count,
`endif
        input  freeze_mem, hazard, flush, id_ctrl, id_payload, id_dest, id_src1, id_src2,
        output exe_ctrl, exe_payload, exe_dest, exe_src1, exe_src2, exe_valid,
               WB_EXE, MEM_R_EN_EXE, pc_freeze, ifid_freeze, ifid_flush, stall_err
    );
endinterface

// File: rtl/id_exe_stall_reg.sv
// ID/EXE pipeline register with load-use stall, branch flush, memory freeze and stall watchdog.
// Optional STALL_STATS_EN macro adds 32-bit stall/flush event counters.
module id_exe_stall_reg #(
    parameter int unsigned PAY_W     = 140,
    parameter int unsigned MAX_STALL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    id_exe_stall_reg_if.slave  bus
);
    localparam int unsigned CTRL_W = 9;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [PAY_W-1:0]    payload_q, payload_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic [REG_W-1:0]    src1_q, src1_d;
    logic [REG_W-1:0]    src2_q, src2_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`ifdef STALL_STATS_EN
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic [31:0]         flush_count_q, flush_count_d;
`endif

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            ctrl_q    <= '0;
            payload_q <= '0;
            dest_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
`ifdef STALL_STATS_EN
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            payload_q <= payload_d;
            dest_q    <= dest_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`ifdef STALL_STATS_EN
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
`endif
        end
    end

    // Next state: freeze_mem > flush > hazard > load; payload is held under a bubble
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        payload_d = payload_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
`ifdef STALL_STATS_EN
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
`endif
        if (bus.freeze_mem) begin
            state_d = state_q;
        end else if (bus.flush) begin
            ctrl_d  = '0;
            dest_d  = '0;
            src1_d  = '0;
            src2_d  = '0;
            valid_d = 1'b0;
            state_d = RUN;
            cnt_d   = '0;
`ifdef STALL_STATS_EN
            flush_count_d = flush_count_q + 32'd1;
`endif
        end else if (bus.hazard) begin
            ctrl_d  = '0;
            dest_d  = '0;
            src1_d  = '0;
            src2_d  = '0;
            valid_d = 1'b0;
            state_d = STALL;
            case (state_q)
                RUN:     cnt_d = CNT_W'(1);
                STALL:   cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : CNT_W'(cnt_q + 1'b1);
                default: cnt_d = '0;
            endcase
            err_d = err_q | (cnt_d >= STALL_LIM);
`ifdef STALL_STATS_EN
            stall_cycles_d = stall_cycles_q + 32'd1;
`endif
        end else begin
            ctrl_d    = bus.id_ctrl;
            payload_d = bus.id_payload;
            dest_d    = bus.id_dest;
            src1_d    = bus.id_src1;
            src2_d    = bus.id_src2;
            valid_d   = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
        end
    end

    // Freeze/flush are same-cycle from inputs, forced low while in reset
    assign bus.pc_freeze   = rst_n & (bus.freeze_mem | (~bus.flush & bus.hazard));
    assign bus.ifid_freeze = rst_n & (bus.freeze_mem | (~bus.flush & bus.hazard));
    assign bus.ifid_flush  = rst_n & ~bus.freeze_mem & bus.flush;

    assign bus.exe_ctrl     = ctrl_q;
    assign bus.exe_payload  = payload_q;
    assign bus.exe_dest     = dest_q;
    assign bus.exe_src1     = src1_q;
    assign bus.exe_src2     = src2_q;
    assign bus.exe_valid    = valid_q;
    assign bus.WB_EXE       = ctrl_q[8];
    assign bus.MEM_R_EN_EXE = ctrl_q[7];
    assign bus.stall_err    = err_q;
`ifdef STALL_STATS_EN
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_id_exe_stall_reg.sv
// Directed bench for id_exe_stall_reg: reset, load, load-use stall, flush, freeze, watchdog.
module tb_id_exe_stall_reg;
    localparam int unsigned PAY_W = 140;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    logic [PAY_W-1:0] p1, p2, p3;

    id_exe_stall_reg_if #(.PAY_W(PAY_W)) bus ();

    id_exe_stall_reg #(.PAY_W(PAY_W), .MAX_STALL(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PAY_W-1:0] rand_pay();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[PAY_W-1:0];
    endfunction

    task automatic set_id(input logic [8:0] c, input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [PAY_W-1:0] p);
        bus.id_ctrl    = c;
        bus.id_dest    = d;
        bus.id_src1    = s1;
        bus.id_src2    = s2;
        bus.id_payload = p;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        p1 = rand_pay();
        p2 = rand_pay();
        p3 = rand_pay();

        // T1: reset with random inputs
        rst_n          = 1'b0;
        bus.freeze_mem = 1'($urandom);
        bus.hazard     = 1'($urandom);
        bus.flush      = 1'($urandom);
        set_id(9'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rand_pay());
        #12;
        check("rst_ctrl",  64'(bus.exe_ctrl), 64'h0);
        check("rst_valid", 64'(bus.exe_valid), 64'h0);
        check("rst_dest",  64'(bus.exe_dest), 64'h0);
        check("rst_wb",    64'(bus.WB_EXE), 64'h0);
        check("rst_err",   64'(bus.stall_err), 64'h0);
        check("rst_pcfrz", 64'(bus.pc_freeze), 64'h0);
        check("rst_ifflu", 64'(bus.ifid_flush), 64'h0);

        @(posedge clk);
        #1;
        bus.freeze_mem = 1'b0;
        bus.hazard     = 1'b0;
        bus.flush      = 1'b0;
        set_id(9'h0F3, 4'd9, 4'd1, 4'd5, p1);
        rst_n = 1'b1;
        step();
        check("t1_ctrl",  64'(bus.exe_ctrl), 64'h0F3);
        check("t1_valid", 64'(bus.exe_valid), 64'h1);
        check("t1_dest",  64'(bus.exe_dest), 64'h9);
        check("t1_pay",   64'(bus.exe_payload == p1), 64'h1);

        // T2: normal load
        set_id(9'h1A5, 4'd4, 4'd2, 4'd3, p2);
        step();
        check("t2_ctrl",  64'(bus.exe_ctrl), 64'h1A5);
        check("t2_dest",  64'(bus.exe_dest), 64'h4);
        check("t2_src1",  64'(bus.exe_src1), 64'h2);
        check("t2_src2",  64'(bus.exe_src2), 64'h3);
        check("t2_valid", 64'(bus.exe_valid), 64'h1);
        check("t2_wb",    64'(bus.WB_EXE), 64'h1);
        check("t2_memr",  64'(bus.MEM_R_EN_EXE), 64'h1);

        // T3: single-cycle load-use stall
        bus.hazard = 1'b1;
        set_id(9'h0C2, 4'd7, 4'd6, 4'd8, p3);
        #1;
        check("t3_pcfrz", 64'(bus.pc_freeze), 64'h1);
        check("t3_iffrz", 64'(bus.ifid_freeze), 64'h1);
        check("t3_ifflu", 64'(bus.ifid_flush), 64'h0);
        step();
        check("t3_bub_ctrl",  64'(bus.exe_ctrl), 64'h0);
        check("t3_bub_valid", 64'(bus.exe_valid), 64'h0);
        check("t3_bub_memr",  64'(bus.MEM_R_EN_EXE), 64'h0);
        check("t3_bub_dest",  64'(bus.exe_dest), 64'h0);
        check("t3_bub_pay",   64'(bus.exe_payload == p2), 64'h1);
        bus.hazard = 1'b0;
        #1;
        check("t3_pcfrz0", 64'(bus.pc_freeze), 64'h0);
        step();
        check("t3_rl_ctrl",  64'(bus.exe_ctrl), 64'h0C2);
        check("t3_rl_valid", 64'(bus.exe_valid), 64'h1);
        check("t3_rl_dest",  64'(bus.exe_dest), 64'h7);
        check("t3_rl_pay",   64'(bus.exe_payload == p3), 64'h1);

        // T4: flush wins over hazard
        bus.flush  = 1'b1;
        bus.hazard = 1'b1;
        #1;
        check("t4_ifflu", 64'(bus.ifid_flush), 64'h1);
        check("t4_pcfrz", 64'(bus.pc_freeze), 64'h0);
        check("t4_iffrz", 64'(bus.ifid_freeze), 64'h0);
        step();
        check("t4_ctrl",  64'(bus.exe_ctrl), 64'h0);
        check("t4_valid", 64'(bus.exe_valid), 64'h0);
        check("t4_err",   64'(bus.stall_err), 64'h0);
        bus.flush  = 1'b0;
        bus.hazard = 1'b0;

        // T5: freeze_mem holds everything, including the stall counter
        set_id(9'h1A5, 4'd4, 4'd2, 4'd3, p2);
        step();
        check("t5_ld_ctrl", 64'(bus.exe_ctrl), 64'h1A5);
        bus.freeze_mem = 1'b1;
        bus.hazard     = 1'b1;
        set_id(9'h0C2, 4'd7, 4'd6, 4'd8, p3);
        #1;
        check("t5_pcfrz", 64'(bus.pc_freeze), 64'h1);
        check("t5_ifflu", 64'(bus.ifid_flush), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_frz_ctrl",  64'(bus.exe_ctrl), 64'h1A5);
            check("t5_frz_valid", 64'(bus.exe_valid), 64'h1);
            check("t5_frz_err",   64'(bus.stall_err), 64'h0);
        end

        // T6: watchdog across a freeze in the middle of a long stall
        bus.freeze_mem = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_st_valid", 64'(bus.exe_valid), 64'h0);
            check("t6_st_err",   64'(bus.stall_err), 64'h0);
        end
        bus.freeze_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_frz_err", 64'(bus.stall_err), 64'h0);
        end
        bus.freeze_mem = 1'b0;
        step();
        check("t6_err_set", 64'(bus.stall_err), 64'h1);
        bus.hazard = 1'b0;
        step();
        check("t6_err_stk",  64'(bus.stall_err), 64'h1);
        check("t6_rl_ctrl",  64'(bus.exe_ctrl), 64'h0C2);
        check("t6_rl_valid", 64'(bus.exe_valid), 64'h1);
        step();
        check("t6_err_stk2", 64'(bus.stall_err), 64'h1);
`ifdef STALL_STATS_EN
        check("st_stalls", 64'(bus.stall_cycles), 64'd4);
        check("st_flushes", 64'(bus.flush_count), 64'd1);
`endif

        // Reset asserted mid-stall clears immediately; next edge behaves as RUN
        bus.hazard = 1'b1;
        step();
        check("rs_stall_valid", 64'(bus.exe_valid), 64'h0);
        rst_n = 1'b0;
        #1;
        check("rs_err",   64'(bus.stall_err), 64'h0);
        check("rs_valid", 64'(bus.exe_valid), 64'h0);
        check("rs_pcfrz", 64'(bus.pc_freeze), 64'h0);
        step();
        bus.hazard = 1'b0;
        set_id(9'h1A5, 4'd4, 4'd2, 4'd3, p2);
        rst_n = 1'b1;
        step();
        check("rs_ctrl",  64'(bus.exe_ctrl), 64'h1A5);
        check("rs_valid1", 64'(bus.exe_valid), 64'h1);
        check("rs_err0",  64'(bus.stall_err), 64'h0);
`ifdef STALL_STATS_EN
        check("rs_stalls", 64'(bus.stall_cycles), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
